// File: rtl/perceptron_layer_seq_if.sv
// Handshake, configuration and result bundle for perceptron_layer_seq.
// The slave modport is the layer; the master modport is its pattern source / consumer.
interface perceptron_layer_seq_if #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8,
    parameter int W_W   = 8
);
    localparam int AW = $clog2(N_OUT * (N_IN + 1));

    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_vec;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [W_W-1:0]   cfg_data;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] out_vec;
    logic             busy;

    modport slave (
        input  in_valid, in_vec, cfg_we, cfg_addr, cfg_data, out_ready,
        output in_ready, out_valid, out_vec, busy
    );

    modport master (
        output in_valid, in_vec, cfg_we, cfg_addr, cfg_data, out_ready,
        input  in_ready, out_valid, out_vec, busy
    );
endinterface

// File: rtl/perceptron_layer_seq.sv
// Time-multiplexed layer of N_OUT binary-input perceptrons, one input bit per cycle.
// Define PCPT_SIGNED_EN for two's-complement weights, thresholds and accumulators.
module perceptron_layer_seq #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8,
    parameter int W_W   = 8
) (
    input logic                  clk,
    input logic                  rst,
    perceptron_layer_seq_if.slave bus
);
    localparam int ACC_W = W_W + $clog2(N_IN + 1);
    localparam int AW    = $clog2(N_OUT * (N_IN + 1));
    localparam int KW    = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {IDLE, RUN, CMP, HOLD} state_t;

    state_t state, state_next;

    logic [W_W-1:0]   w   [N_OUT][N_IN];
    logic [W_W-1:0]   thr [N_OUT];
    logic [ACC_W-1:0] acc [N_OUT];
    logic [N_IN-1:0]  in_vec_q;
    logic [KW-1:0]    k;
    logic [N_OUT-1:0] out_vec_q;
    logic             out_valid_q;
    logic             in_ready;
    logic             busy;

    function automatic logic [ACC_W-1:0] extend(input logic [W_W-1:0] v);
`ifdef PCPT_SIGNED_EN
        return ACC_W'($signed(v));
`else
        return ACC_W'(v);
`endif
    endfunction

    function automatic logic fires(input logic [ACC_W-1:0] a, input logic [W_W-1:0] t);
`ifdef PCPT_SIGNED_EN
        return $signed(a) > $signed(extend(t));
`else
        return a > extend(t);
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: combinational process assigns every output a default first, so no latch can form.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (bus.in_valid) state_next = RUN;
            end
            RUN:  if (k == KW'(N_IN - 1)) state_next = CMP;
            CMP:  state_next = HOLD;
            HOLD: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the register file is reset explicitly; a reset must leave the layer with all-zero weights.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < N_OUT; n++) begin
                for (int j = 0; j < N_IN; j++) w[n][j] <= '0;
                thr[n] <= '0;
                acc[n] <= '0;
            end
            in_vec_q    <= '0;
            k           <= '0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // Writes are only honoured in IDLE so weights never change mid-pass.
            if (state == IDLE && bus.cfg_we) begin
                for (int n = 0; n < N_OUT; n++) begin
                    for (int j = 0; j < N_IN; j++)
                        if (bus.cfg_addr == AW'(n * (N_IN + 1) + j)) w[n][j] <= bus.cfg_data;
                    if (bus.cfg_addr == AW'(n * (N_IN + 1) + N_IN)) thr[n] <= bus.cfg_data;
                end
            end

            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_vec_q <= bus.in_vec;
                        k        <= '0;
                        for (int n = 0; n < N_OUT; n++) acc[n] <= '0;
                    end
                end
                RUN: begin
                    for (int n = 0; n < N_OUT; n++)
                        if (in_vec_q[k]) acc[n] <= acc[n] + extend(w[n][k]);
                    k <= k + KW'(1);
                end
                CMP: begin
                    for (int n = 0; n < N_OUT; n++) out_vec_q[n] <= fires(acc[n], thr[n]);
                    out_valid_q <= 1'b1;
                end
                HOLD: if (bus.out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = out_vec_q;
endmodule

// File: tb/tb_perceptron_layer_seq.sv
// Self-checking bench for perceptron_layer_seq: table-driven vectors, scoreboard queue,
// and hand-written sequences for latency, backpressure, config lockout and mid-run reset.
module tb_perceptron_layer_seq;
    localparam int N_IN  = 8;
    localparam int N_OUT = 8;
    localparam int W_W   = 8;
    localparam int AW    = $clog2(N_OUT * (N_IN + 1));
    localparam int DEPTH = N_OUT * (N_IN + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    perceptron_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W)) bus ();

    perceptron_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] thr;
        logic [7:0] vec;
        logic [7:0] expv;
        string      name;
    } vec_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mw   [N_OUT][N_IN];
    logic [7:0] mthr [N_OUT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic void model_clear();
        for (int n = 0; n < N_OUT; n++) begin
            for (int j = 0; j < N_IN; j++) mw[n][j] = 8'h00;
            mthr[n] = 8'h00;
        end
    endfunction

    function automatic logic [7:0] model_out(input logic [7:0] v);
        logic [7:0] r;
        int s, t;
        r = '0;
        for (int n = 0; n < N_OUT; n++) begin
            s = 0;
            for (int j = 0; j < N_IN; j++) begin
`ifdef PCPT_SIGNED_EN
                if (v[j]) s += int'($signed(mw[n][j]));
`else
                if (v[j]) s += int'(mw[n][j]);
`endif
            end
`ifdef PCPT_SIGNED_EN
            t = int'($signed(mthr[n]));
`else
            t = int'(mthr[n]);
`endif
            r[n] = (s > t);
        end
        return r;
    endfunction

    // Write one entry while the DUT is idle and mirror it into the bench's model.
    task automatic cfg_write(input int a, input logic [7:0] d);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_data = d;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
        if (a < DEPTH) begin
            if (a % (N_IN + 1) == N_IN) mthr[a / (N_IN + 1)] = d;
            else mw[a / (N_IN + 1)][a % (N_IN + 1)] = d;
        end
    endtask

    // Wait for a result, compare it to the scoreboard head, then complete the handshake.
    task automatic finish_vec(input string name);
        int t;
        logic [7:0] expv;
        t = 0;
        while (!bus.out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        expv = exp_q.pop_front();
        if (!bus.out_valid) begin
            timeout_fail(name);
            return;
        end
        check(name, bus.out_vec, expv);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(input logic [7:0] v, input logic [7:0] expv, input string name);
        int t;
        exp_q.push_back(expv);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        t = 0;
        while (!bus.in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            void'(exp_q.pop_front());
            timeout_fail({name, "_accept"});
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        finish_vec(name);
    endtask

    initial begin
        vec_t       tbl[5];
        logic       seen;
        logic [7:0] v;

        tbl[0] = '{8'd0,  8'hFF, 8'h01, "w20_thr0"};
        tbl[1] = '{8'd19, 8'hFF, 8'h01, "w20_thr19"};
        tbl[2] = '{8'd20, 8'hFF, 8'h00, "w20_thr20"};
        tbl[3] = '{8'd4,  8'h10, 8'h01, "k4_thr4"};
        tbl[4] = '{8'd5,  8'h10, 8'h00, "k4_thr5"};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.out_ready = 1'b0;
        model_clear();

        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_vec",   bus.out_vec,   8'h00);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_busy",      bus.busy,      1'b0);
        rst = 1'b0;

        run_vec(8'hFF, 8'h00, "zero_config");

        begin
            logic [7:0] wts[N_IN];
            wts = '{8'd2, 8'd4, 8'd2, 8'd1, 8'd5, 8'd2, 8'd2, 8'd2};
            for (int j = 0; j < N_IN; j++) cfg_write(j, wts[j]);
        end
        for (int i = 0; i < 5; i++) begin
            cfg_write(N_IN, tbl[i].thr);
            run_vec(tbl[i].vec, tbl[i].expv, tbl[i].name);
        end

        // Latency and backpressure: accept at edge T, result visible after edge T+9.
        cfg_write(N_IN, 8'd19);
        exp_q.push_back(8'h01);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_vec   = 8'hFF;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("lat_busy", bus.busy, 1'b1);
        check("lat_in_ready", bus.in_ready, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 8) check("lat_not_yet", bus.out_valid, 1'b0);
            if (i == 9) begin
                check("lat_valid", bus.out_valid, 1'b1);
                check("lat_vec", bus.out_vec, exp_q.pop_front());
            end
        end
        bus.in_valid = 1'b1;
        bus.in_vec   = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_vec", bus.out_vec, 8'h01);
            check("hold_in_ready", bus.in_ready, 1'b0);
            check("hold_valid", bus.out_valid, 1'b1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("hs_valid_low", bus.out_valid, 1'b0);
        check("hs_in_ready", bus.in_ready, 1'b1);
        check("hs_busy", bus.busy, 1'b0);
        check("hs_vec_kept", bus.out_vec, 8'h01);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        check("ignored_in_valid", seen, 1'b0);

        // Config write during RUN must be dropped.
        cfg_write(N_IN, 8'd20);
        exp_q.push_back(model_out(8'h01));
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_vec   = 8'h01;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(0);
        bus.cfg_data = 8'hFF;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
        finish_vec("lockout_pass");
        run_vec(8'h01, 8'h00, "lockout_rerun");

        cfg_write(DEPTH, 8'hFF);
        cfg_write(2 ** AW - 1, 8'hFF);
        run_vec(8'hFF, model_out(8'hFF), "addr_out_of_range");

        // Write and accept on the same edge: the first RUN cycle sees the new weight.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_vec   = 8'h01;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(0);
        bus.cfg_data = 8'd30;
        mw[0][0]     = 8'd30;
        exp_q.push_back(model_out(8'h01));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        finish_vec("simul_cfg_accept");

        cfg_write(0, 8'hFF);
        cfg_write(N_IN, 8'hFE);
        run_vec(8'h01, 8'h01, "sign_ff_gt_fe");
        cfg_write(N_IN, 8'h00);
`ifdef PCPT_SIGNED_EN
        run_vec(8'h01, 8'h00, "sign_ff_vs_0");
`else
        run_vec(8'h01, 8'h01, "sign_ff_vs_0");
`endif

        for (int a = 0; a < DEPTH; a++) cfg_write(a, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 6; i++) begin
            v = 8'($urandom_range(0, 255));
            run_vec(v, model_out(v), "random_model");
        end

        // Reset mid-pass discards the result and clears the register file.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_vec   = 8'hFF;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", bus.out_valid, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        check("midrst_vec", bus.out_vec, 8'h00);
        rst = 1'b0;
        model_clear();
        run_vec(8'hFF, 8'h00, "post_rst_cleared");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
